// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, ALU operation
// encoding, bubble instruction and the funct3/funct7 -> ALU op mapping.
package decode_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle; master is the decode stage.
interface decode_if;
  import decode_pkg::*;

  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  alu_op_e     id_alu_op;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  logic        id_illegal;

  modport master (
    input  if_pc, if_instr, if_valid,
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_illegal
  );

  modport slave (
    output if_pc, if_instr, if_valid,
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           id_branch, id_jump, id_illegal
  );

endinterface

// File: rtl/register_file.sv
// 32x32 register file, two async read ports, one sync write port, sync reset.
// DECODE_FORWARD_EN: a same-cycle write to a read address is bypassed to the read port.
module register_file
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  // x0 has no storage; it is hardwired to zero on the read side
  logic [XLEN-1:0] regs [1:31];
  logic            hit_a;
  logic            hit_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef DECODE_FORWARD_EN
  assign hit_a = we && (waddr == raddr_a);
  assign hit_b = we && (waddr == raddr_b);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  assign rdata_a = (raddr_a == 5'd0) ? '0 : (hit_a ? wdata : regs[raddr_a]);
  assign rdata_b = (raddr_b == 5'd0) ? '0 : (hit_b ? wdata : regs[raddr_b]);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, combinational decode and register read.
// Optional DECODE_FORWARD_EN enables write-through bypass in the register file.
module decode_stage
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  decode_if.master        bus,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (!stall) begin
      valid_q <= bus.if_valid;
      pc_q    <= bus.if_pc;
      instr_q <= bus.if_instr;
    end
  end

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm;
  alu_op_e     alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;

  assign opcode = instr_q[6:0];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'h000};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    imm       = '0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm = imm_u; alu_op = ALU_PASSB; alu_src = 1'b1; reg_write = 1'b1; end
      OPC_AUIPC:  begin imm = imm_u; alu_src = 1'b1; reg_write = 1'b1; end
      OPC_JAL:    begin imm = imm_j; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; end
      OPC_JALR:   begin imm = imm_i; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; end
      OPC_BRANCH: begin imm = imm_b; alu_op = ALU_SUB; branch = 1'b1; end
      OPC_LOAD:   begin imm = imm_i; alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
      OPC_STORE:  begin imm = imm_s; alu_src = 1'b1; mem_write = 1'b1; end
      OPC_OP_IMM: begin
        // funct7[5] only distinguishes SRAI; for ADDI the upper imm bits are data
        imm       = imm_i;
        alu_op    = alu_op_from_funct(instr_q[14:12], (instr_q[14:12] == 3'b101) && instr_q[30]);
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OPC_OP:     begin alu_op = alu_op_from_funct(instr_q[14:12], instr_q[30]); reg_write = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end

  register_file u_register_file (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (instr_q[19:15]),
    .raddr_b (instr_q[24:20]),
    .rdata_a (bus.id_rs1_data),
    .rdata_b (bus.id_rs2_data)
  );

  assign bus.id_valid     = valid_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_rs1       = instr_q[19:15];
  assign bus.id_rs2       = instr_q[24:20];
  assign bus.id_rd        = instr_q[11:7];
  assign bus.id_imm       = imm;
  assign bus.id_alu_op    = alu_op;
  // bubbles must not side-effect downstream, so all controls are qualified by valid
  assign bus.id_alu_src   = valid_q & alu_src;
  assign bus.id_reg_write = valid_q & reg_write;
  assign bus.id_mem_read  = valid_q & mem_read;
  assign bus.id_mem_write = valid_q & mem_write;
  assign bus.id_branch    = valid_q & branch;
  assign bus.id_jump      = valid_q & jump;
  assign bus.id_illegal   = valid_q & illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan steps followed by
// randomized traffic checked against an instruction-level reference model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  decode_if dif ();

  decode_stage dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (dif),
    .stall   (stall),
    .flush   (flush),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference state: architectural registers and the instruction held in decode
  logic [31:0] rf [32];
  logic        exp_v;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;

  typedef struct {
    logic [31:0] imm;
    logic [3:0]  alu;
    logic src, rw, mr, mw, br, jp, ill;
  } dec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic dec_t ref_decode(input logic [31:0] ins, input logic v);
    dec_t d;
    logic [3:0] f3_map [8];
    int   t;
    logic [2:0] f3;
    f3_map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = ins[14:12];
    d = '{imm: 32'h0, alu: ALU_ADD, default: 1'b0};
    case (ins[6:0])
      OPC_LUI:    begin d.imm = ins & 32'hFFFF_F000; d.alu = ALU_PASSB; d.src = 1; d.rw = 1; end
      OPC_AUIPC:  begin d.imm = ins & 32'hFFFF_F000; d.src = 1; d.rw = 1; end
      OPC_JAL:    begin
        t = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]}));
        d.imm = 32'(t * 2); d.src = 1; d.rw = 1; d.jp = 1;
      end
      OPC_JALR:   begin t = int'($signed(ins[31:20])); d.imm = 32'(t); d.src = 1; d.rw = 1; d.jp = 1; end
      OPC_BRANCH: begin
        t = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]}));
        d.imm = 32'(t * 2); d.alu = ALU_SUB; d.br = 1;
      end
      OPC_LOAD:   begin t = int'($signed(ins[31:20])); d.imm = 32'(t); d.src = 1; d.rw = 1; d.mr = 1; end
      OPC_STORE:  begin
        t = int'($signed({ins[31:25], ins[11:7]}));
        d.imm = 32'(t); d.src = 1; d.mw = 1;
      end
      OPC_OP_IMM: begin
        t = int'($signed(ins[31:20])); d.imm = 32'(t); d.src = 1; d.rw = 1;
        d.alu = (f3 == 3'd5 && ins[30]) ? ALU_SRA : f3_map[f3];
      end
      OPC_OP:     begin
        d.rw = 1;
        if (f3 == 3'd0 && ins[30])      d.alu = ALU_SUB;
        else if (f3 == 3'd5 && ins[30]) d.alu = ALU_SRA;
        else                            d.alu = f3_map[f3];
      end
      default:    d.ill = 1;
    endcase
    if (!v) begin
      d.src = 0; d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.jp = 0; d.ill = 0;
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef DECODE_FORWARD_EN
    if (wb_we && wb_rd == a) return wb_data;
`endif
    return rf[a];
  endfunction

  // advance one clock, updating the reference with the inputs seen at the edge
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      exp_v = 0; exp_pc = 0; exp_ins = NOP_INSTR;
    end else begin
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
      if (flush) begin
        exp_v = 0; exp_pc = 0; exp_ins = NOP_INSTR;
      end else if (!stall) begin
        exp_v = dif.if_valid; exp_pc = dif.if_pc; exp_ins = dif.if_instr;
      end
    end
    #1;
  endtask

  task automatic check_all(input string ctx);
    dec_t e;
    e = ref_decode(exp_ins, exp_v);
    check({ctx, ".valid"},     32'(dif.id_valid),     32'(exp_v));
    check({ctx, ".pc"},        dif.id_pc,             exp_pc);
    check({ctx, ".rs1"},       32'(dif.id_rs1),       32'(exp_ins[19:15]));
    check({ctx, ".rs2"},       32'(dif.id_rs2),       32'(exp_ins[24:20]));
    check({ctx, ".rd"},        32'(dif.id_rd),        32'(exp_ins[11:7]));
    check({ctx, ".rs1_data"},  dif.id_rs1_data,       exp_read(exp_ins[19:15]));
    check({ctx, ".rs2_data"},  dif.id_rs2_data,       exp_read(exp_ins[24:20]));
    check({ctx, ".imm"},       dif.id_imm,            e.imm);
    check({ctx, ".alu_op"},    32'(dif.id_alu_op),    32'(e.alu));
    check({ctx, ".alu_src"},   32'(dif.id_alu_src),   32'(e.src));
    check({ctx, ".reg_write"}, 32'(dif.id_reg_write), 32'(e.rw));
    check({ctx, ".mem_read"},  32'(dif.id_mem_read),  32'(e.mr));
    check({ctx, ".mem_write"}, 32'(dif.id_mem_write), 32'(e.mw));
    check({ctx, ".branch"},    32'(dif.id_branch),    32'(e.br));
    check({ctx, ".jump"},      32'(dif.id_jump),      32'(e.jp));
    check({ctx, ".illegal"},   32'(dif.id_illegal),   32'(e.ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] w;
    opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
             OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, 7'b1110011};
    w = $urandom;
    if ($urandom_range(9) == 0) return w;
    w[6:0] = opcs[$urandom_range(9)];
    return w;
  endfunction

  task automatic drive_if(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    dif.if_valid = v; dif.if_pc = pc; dif.if_instr = ins;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    drive_if(0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    exp_v = 0; exp_pc = 0; exp_ins = NOP_INSTR;

    // reset for two cycles, then release with nothing valid
    step(); step();
    reset = 0;
    step();
    check_all("reset");
    check("reset.valid_c", 32'(dif.id_valid), 32'h0);
    check("reset.imm_c",   dif.id_imm,        32'h0);
    check("reset.alu_c",   32'(dif.id_alu_op), 32'(ALU_ADD));

    // addi x1,x0,5
    drive_if(1, 32'h0, 32'h0050_0093);
    step();
    check_all("addi");
    check("addi.rd_c",  32'(dif.id_rd),        32'd1);
    check("addi.imm_c", dif.id_imm,            32'd5);
    check("addi.rw_c",  32'(dif.id_reg_write), 32'd1);
    check("addi.src_c", 32'(dif.id_alu_src),   32'd1);

    // write x5, then add x6,x5,x0
    drive_if(0, 32'h4, 32'h0);
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
    step();
    wb_we = 0;
    drive_if(1, 32'h8, 32'h0002_8333);
    step();
    check_all("add");
    check("add.rs1_data_c", dif.id_rs1_data,    32'hDEAD_BEEF);
    check("add.rs2_data_c", dif.id_rs2_data,    32'h0);
    check("add.rd_c",       32'(dif.id_rd),     32'd6);
    check("add.src_c",      32'(dif.id_alu_src), 32'd0);

    // beq x0,x0,-4 at 0x100, held by stall while fetch moves on
    drive_if(1, 32'h100, 32'hFE00_0EE3);
    step();
    check_all("beq");
    check("beq.imm_c", dif.id_imm,             32'hFFFF_FFFC);
    check("beq.alu_c", 32'(dif.id_alu_op),     32'(ALU_SUB));
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_if(1, 32'h104 + 32'(4 * i), 32'h0050_0093 + 32'(i << 7));
      step();
      check_all("stall");
      check("stall.pc_c",     dif.id_pc,             32'h100);
      check("stall.branch_c", 32'(dif.id_branch),    32'd1);
    end
    flush = 1;
    step();
    check_all("flush_stall");
    check("flush_stall.valid_c", 32'(dif.id_valid), 32'd0);
    flush = 0; stall = 0;

    // illegal instruction, then an x0 write that must be dropped
    drive_if(1, 32'h200, 32'hFFFF_FFFF);
    step();
    check_all("illegal");
    check("illegal.ill_c", 32'(dif.id_illegal),   32'd1);
    check("illegal.rw_c",  32'(dif.id_reg_write), 32'd0);
    wb_we = 1; wb_rd = 0; wb_data = 32'h7;
    drive_if(1, 32'h204, 32'h0000_0033);
    step();
    wb_we = 0;
    #1;
    check_all("x0");
    check("x0.rs1_data_c", dif.id_rs1_data, 32'h0);

    // same-cycle write and read of x3
    wb_we = 1; wb_rd = 3; wb_data = 32'h0BAD_F00D;
    drive_if(1, 32'h208, 32'h0001_8093);
    step();
    wb_we = 0;
    #1;
    check("wt.old_c", dif.id_rs1_data, 32'h0BAD_F00D);
    stall = 1;
    wb_we = 1; wb_rd = 3; wb_data = 32'h1234_5678;
    #1;
    check_all("wt_same");
`ifdef DECODE_FORWARD_EN
    check("wt.same_c", dif.id_rs1_data, 32'h1234_5678);
`else
    check("wt.same_c", dif.id_rs1_data, 32'h0BAD_F00D);
`endif
    step();
    wb_we = 0;
    #1;
    check_all("wt_next");
    check("wt.next_c", dif.id_rs1_data, 32'h1234_5678);
    stall = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      drive_if(1'($urandom_range(1)), $urandom, rand_instr());
      wb_we   = 1'($urandom_range(1));
      wb_rd   = ($urandom_range(2) == 0) ? exp_ins[19:15] : 5'($urandom);
      wb_data = $urandom;
      #1;
      check_all("rnd_pre");
      step();
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Stage directly downstream of instruction fetch. Captures the fetched instruction and its PC in an IF/ID pipeline register.
- Decodes RV32I fields, immediates and control signals, and reads the 32x32 register file.
- Presents the operands to the execute stage.
- Accepts stall/flush from hazard control and the register write-back port from the WB stage.

Parameters:
- XLEN, 32, datapath width
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_pc  in  32  PC of fetched instruction
- if_instr  in  32  instruction word from instruction memory
- if_valid  in  1  fetch output valid
- stall  in  1  hold IF/ID register
- flush  in  1  squash IF/ID content (taken branch/jump)
- wb_we  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  32  write data
- id_valid  out  1  decoded instruction valid
- id_pc  out  32  PC of decoded instruction
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_rs1_data, id_rs2_data  out  32 each  operand values
- id_imm  out  32  sign-extended immediate
- id_alu_op  out  4  ALU operation (package enum)
- id_alu_src  out  1  1 = immediate is operand B
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  out  1 each  control
- id_illegal  out  1  unsupported opcode

Behaviour:
- IF/ID register updates on rising clk. Priority per cycle: reset > flush > stall > load.
  - reset or flush: valid=0, pc=0, instr=NOP_INSTR.
  - stall: hold.
  - Otherwise: capture if_valid, if_pc, if_instr.
  - flush with stall in the same cycle results in a flush.
- Latency: an instruction presented in cycle N appears decoded on id_* in cycle N+1. Decode and register read are combinational from the IF/ID register.
- After reset: id_valid=0, id_pc=0, all control outputs 0, id_alu_op=ADD, id_imm=0, id_rd/rs1/rs2=0.
- When id_valid=0, reg_write, mem_read, mem_write, branch, jump and illegal are forced to 0.
- Immediate formats: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0). All sign-extended from instr[31]. R-type gives imm=0.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Any other opcode, or instr[1:0]!=2'b11: id_illegal=1, all other controls 0.
- ALU op:
  - OP: from funct3 + funct7[5].
  - OP-IMM: funct7[5] used only for SRAI.
  - LUI: PASSB.
  - Loads, stores, AUIPC, JAL, JALR: ADD.
  - Branches: SUB.
- Register file:
  - 32x32, written on rising clk when wb_we && wb_rd!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - reset clears all registers to 0.
  - Reads are asynchronous.
- Simultaneous write and read of the same register: behaviour set by the optional feature below.

Optional Feature:
- Macro: DECODE_FORWARD_EN.
- Defined: write-through bypass. When wb_we && wb_rd!=0 && wb_rd==id_rs1 (or id_rs2), the matching id_rsX_data returns wb_data in the same cycle.
- Undefined: the read returns the old stored value. The new value is visible from the next cycle.

Decomposition:
- Package decode_pkg holds:
  - Opcode constants.
  - alu_op_e enum, 4-bit: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - NOP_INSTR.
- Sub-module register_file (2 async read ports, 1 sync write port, sync reset) is instantiated inside decode_stage.

Test Plan:
- Reset asserted 2 cycles, then released with if_valid=0 -> id_valid=0, all controls 0, id_pc=0, id_imm=0.
- if_pc=0x0, if_instr=0x00500093 (addi x1,x0,5), valid -> next cycle:
  - id_valid=1, id_rd=1, id_rs1=0, id_imm=5
  - alu_op=ADD, alu_src=1, reg_write=1
- wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; one cycle later present 0x00028333 (add x6,x5,x0) -> id_rs1_data=0xDEADBEEF, id_rs2_data=0, id_rd=6, alu_src=0.
- Present 0xFE000EE3 (beq x0,x0,-4) at pc 0x100, then hold stall=1 for 3 cycles with new if_instr:
  - id_imm=0xFFFFFFFC, id_branch=1, alu_op=SUB, id_pc=0x100 held throughout the stall.
  - Then flush=1 together with stall=1 -> id_valid=0 next cycle.
- Present 0xFFFFFFFF -> id_illegal=1, reg_write=0, mem_read=0, mem_write=0. Write wb_rd=0, wb_data=7, then read x0 -> 0.
- Same-cycle wb_we=1, wb_rd=3, wb_data=0x12345678 while id_rs1=3:
  - With DECODE_FORWARD_EN: id_rs1_data=0x12345678 that cycle.
  - Without: old value that cycle, 0x12345678 the next.
